// File: rtl/clk_div_pkg.sv
// Purpose: shared types and constants for the clk_div_n rate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block).
package clk_div_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Smallest divisor the generator accepts; anything below is flagged on err.
  localparam int MIN_DIV = 2;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/clk_div_cfg.sv
// Purpose: divisor/mode configuration store with shadow and active copies.
// Latency: a legal load reaches the active copy on the first commit edge at or after the load.
// Backpressure: none; a load is always accepted or rejected in its own cycle.
//
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   div_load        one-cycle strobe capturing div_val / mode_in
//   div_val         requested divisor
//   mode_in         requested mode (MODE_PULSE / MODE_SQUARE)
//   commit          high in cycles where the active copy may change (period boundary, idle, stop)
//   act_div         divisor currently driving the counter
//   act_mode        mode currently driving the output decode
//   err             one-cycle pulse, the cycle after a rejected load
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 3,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             mode_in,
  input  logic             commit,
  output logic [WIDTH-1:0] act_div,
  output logic             act_mode,
  output logic             err
);

  logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic             act_mode_q, act_mode_d;
  logic             err_q, err_d;
  logic             load_ok;

  assign load_ok = div_load && (div_val >= WIDTH'(MIN_DIV));

  always_comb begin
    shadow_div_d  = shadow_div_q;
    shadow_mode_d = shadow_mode_q;
    pending_d     = pending_q;
    act_div_d     = act_div_q;
    act_mode_d    = act_mode_q;
    err_d         = div_load && !load_ok;

    if (load_ok) begin
      shadow_div_d  = div_val;
      shadow_mode_d = mode_in;
      pending_d     = 1'b1;
    end

    // Using the _d shadows lets a load in the commit cycle itself take effect.
    if (commit && pending_d) begin
      act_div_d  = shadow_div_d;
      act_mode_d = shadow_mode_d;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_div_q  <= WIDTH'(DEFAULT_DIV);
      shadow_mode_q <= (DEFAULT_MODE != 0);
      pending_q     <= 1'b0;
      act_div_q     <= WIDTH'(DEFAULT_DIV);
      act_mode_q    <= (DEFAULT_MODE != 0);
      err_q         <= 1'b0;
    end else begin
      shadow_div_q  <= shadow_div_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q     <= pending_d;
      act_div_q     <= act_div_d;
      act_mode_q    <= act_mode_d;
      err_q         <= err_d;
    end
  end

  assign act_div  = act_div_q;
  assign act_mode = act_mode_q;
  assign err      = err_q;

endmodule

// File: rtl/clk_div_n.sv
// Purpose: runtime-programmable divide-by-N pulse / square-wave generator (Moore FSM).
// Latency: y is high in the first cycle after the edge that samples en = 1.
// Backpressure: none; config changes are deferred to period boundaries, never stalled.
//
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   en              run enable; low returns to idle with the phase cleared
//   div_load        one-cycle strobe capturing div_val / mode_in
//   div_val         requested divisor N (legal range 2 .. 2^WIDTH-1)
//   mode_in         0 = one pulse per period, 1 = near-50% square wave
//   y               divided output, decoded from registered state
//   tick            high in the last cycle of every period
//   err             one-cycle pulse after a rejected load
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 3,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             mode_in,
  output logic             y,
  output logic             tick,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div;
  logic             act_mode;
  logic             last_cnt;
  logic             commit;
  logic [WIDTH:0]   sq_high;

  assign last_cnt = (cnt_q == (act_div - WIDTH'(1)));
  assign tick     = (state_q == S_RUN) && last_cnt;

  // Config may only change where it cannot cut a period short: while idle,
  // at the wrap, or on the edge that stops the generator.
  assign commit = (state_q == S_IDLE) || tick || !en;

  // High-phase length ceil(N/2); one extra bit so N = 2^WIDTH-1 cannot overflow.
  assign sq_high = ({1'b0, act_div} + (WIDTH + 1)'(1)) >> 1;

  clk_div_cfg #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_MODE (DEFAULT_MODE)
  ) u_cfg (
    .clk      (clk),
    .reset    (reset),
    .div_load (div_load),
    .div_val  (div_val),
    .mode_in  (mode_in),
    .commit   (commit),
    .act_div  (act_div),
    .act_mode (act_mode),
    .err      (err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (last_cnt) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    y = 1'b0;
    if (state_q == S_RUN) begin
      case (act_mode)
        MODE_PULSE:  y = (cnt_q == '0);
        MODE_SQUARE: y = ({1'b0, cnt_q} < sq_high);
      endcase
    end
  end

endmodule
